// File: rtl/fifo_arb_pkg.sv
// Shared types and default parameters for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_STALL = 2'd2
  } arb_state_e;

  localparam int unsigned N_REQ_DEF      = 4;
  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned BURST_LEN_DEF  = 2;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin scan: first set request at or after start, with wrap.
module rr_priority_picker #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    start,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  logic [IW:0] j;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = {1'b0, start} + (IW+1)'(k);
      if (j >= (IW+1)'(N_REQ)) j = j - (IW+1)'(N_REQ);
      if (!valid && req[IW'(j)]) begin
        idx   = IW'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one registered FIFO write port among N_REQ producers,
// with per-owner burst lock, full/almost-full throttling and sticky error flags.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned N_REQ      = N_REQ_DEF,
  parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int unsigned BURST_LEN  = BURST_LEN_DEF,
  localparam int unsigned OW         = $clog2(N_REQ),
  localparam int unsigned BW         = $clog2(BURST_LEN + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_data_in,
  input  logic                        fifo_full,
  input  logic                        fifo_almostfull,
  input  logic                        fifo_wr_ack,
  input  logic                        fifo_overflow,
  output logic [OW-1:0]               owner,
  output logic                        busy,
  output logic                        err_overflow,
  output logic                        err_ack
);

  arb_state_e    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [OW-1:0] start, pick_idx, eff_owner;
  logic          any_req, can_issue, rotate, issue;
  logic          wr_en_q;

  rr_priority_picker #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .start (start),
    .idx   (pick_idx),
    .valid (any_req)
  );

  // The almost-full term covers the write already registered on fifo_wr_en.
  assign can_issue = !fifo_full && !(fifo_almostfull && fifo_wr_en);
  assign rotate    = (state_q == ARB_IDLE) || !req[owner_q] || (beat_q == BW'(BURST_LEN));
  assign start     = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);
  assign eff_owner = rotate ? pick_idx : owner_q;
  assign issue     = any_req && can_issue && !rst;
  assign gnt       = issue ? (N_REQ'(1) << eff_owner) : '0;

  assign owner = owner_q;
  assign busy  = (state_q != ARB_IDLE);

  // Next-state: a stall keeps the owner slot but neither counts nor rotates.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    if (!any_req) begin
      state_d = ARB_IDLE;
      beat_d  = '0;
    end else if (can_issue) begin
      state_d = ARB_GRANT;
      owner_d = eff_owner;
      beat_d  = rotate ? BW'(1) : beat_q + BW'(1);
    end else begin
      state_d = ARB_STALL;
      owner_d = eff_owner;
      beat_d  = rotate ? '0 : beat_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OW'(N_REQ - 1);
      beat_q       <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      wr_en_q      <= 1'b0;
      err_overflow <= 1'b0;
      err_ack      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_q     <= beat_d;
      fifo_wr_en <= issue;
      if (issue) fifo_data_in <= req_data[eff_owner*DATA_WIDTH +: DATA_WIDTH];
      wr_en_q      <= fifo_wr_en;
      err_overflow <= err_overflow | fifo_overflow;
      err_ack      <= err_ack | (wr_en_q && !fifo_wr_ack);
    end
  end

endmodule
